// File: rtl/rip_axi_const.sv
// rtl/rip_axi_const.sv - shared AXI response/burst codes and responder FSM states
package rip_axi_const;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/rip_axi_interface.sv
// rtl/rip_axi_interface.sv - AXI4 AW/W/B/AR/R bundle with master and slave views
interface rip_axi_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );
endinterface

// File: rtl/rip_axi_ram_array.sv
// rtl/rip_axi_ram_array.sv - word array, one byte-enabled write port, one async read port
module rip_axi_ram_array #(
    parameter int WORDS = 1024,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [WORDS];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rip_axi_ram_responder.sv
// rtl/rip_axi_ram_responder.sv - AXI4 RAM responder; RIP_AXI_RAM_RANGE_CHECK_EN adds window range checking
module rip_axi_ram_responder
    import rip_axi_const::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_base,
    output logic [1:0]            busy,
    rip_axi_interface.slave       S_AXI
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    w_state_e                w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d, w_base_q, w_base_d;
    logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]              w_burst_q, w_burst_d, b_resp_q, b_resp_d;
    logic                    w_err_q, w_err_d;

    r_state_e                r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d, r_base_q, r_base_d;
    logic [7:0]              r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]              r_burst_q, r_burst_d;

    logic                    w_oor, r_oor, w_beat_err, r_err, w_beat_last, r_last, mem_we;
    logic [IDX_W-1:0]        w_idx, r_idx;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;

    assign w_idx = IDX_W'((w_addr_q - w_base_q) >> 2);
    assign r_idx = IDX_W'((r_addr_q - r_base_q) >> 2);

`ifdef RIP_AXI_RAM_RANGE_CHECK_EN
    assign w_oor = (w_addr_q < w_base_q) || (((w_addr_q - w_base_q) >> 2) >= ADDR_WIDTH'(MEM_WORDS));
    assign r_oor = (r_addr_q < r_base_q) || (((r_addr_q - r_base_q) >> 2) >= ADDR_WIDTH'(MEM_WORDS));
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    // WRAP bursts are carried through to completion but never touch the array.
    assign w_beat_err  = (w_burst_q == BURST_WRAP) || w_oor;
    assign r_err       = (r_burst_q == BURST_WRAP) || r_oor;
    assign w_beat_last = (w_cnt_q == w_len_q);
    assign r_last      = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign mem_we      = (w_state_q == W_DATA) && S_AXI.WVALID && !w_beat_err;

    rip_axi_ram_array #(.WORDS(MEM_WORDS)) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .be_i    (S_AXI.WSTRB),
        .waddr_i (w_idx),
        .wdata_i (S_AXI.WDATA),
        .raddr_i (r_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_base_d  = w_base_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        b_resp_d  = b_resp_q;
        case (w_state_q)
            W_IDLE: if (S_AXI.AWVALID) begin
                w_id_d    = S_AXI.AWID;
                w_addr_d  = S_AXI.AWADDR;
                w_base_d  = mem_base;
                w_len_d   = S_AXI.AWLEN;
                w_burst_d = S_AXI.AWBURST;
                w_cnt_d   = 8'd0;
                w_err_d   = 1'b0;
                b_resp_d  = RESP_OKAY;
                w_state_d = W_DATA;
            end
            W_DATA: if (S_AXI.WVALID) begin
                w_err_d = w_err_q | w_beat_err;
                w_cnt_d = w_cnt_q + 8'd1;
                if (w_burst_q != BURST_FIXED) w_addr_d = w_addr_q + ADDR_WIDTH'(4);
                // Burst ends on WLAST or on the final counted beat, whichever comes first.
                if (S_AXI.WLAST || w_beat_last) begin
                    w_state_d = W_RESP;
                    b_resp_d  = (w_err_q || w_beat_err || (S_AXI.WLAST != w_beat_last))
                                ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: if (S_AXI.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_base_d  = r_base_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        case (r_state_q)
            R_IDLE: if (S_AXI.ARVALID) begin
                r_id_d    = S_AXI.ARID;
                r_addr_d  = S_AXI.ARADDR;
                r_base_d  = mem_base;
                r_len_d   = S_AXI.ARLEN;
                r_burst_d = S_AXI.ARBURST;
                r_cnt_d   = 8'd0;
                r_state_d = R_DATA;
            end
            R_DATA: if (S_AXI.RREADY) begin
                if (r_last) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (r_burst_q != BURST_FIXED) r_addr_d = r_addr_q + ADDR_WIDTH'(4);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            b_resp_q  <= RESP_OKAY;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_base_q  <= w_base_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            b_resp_q  <= b_resp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_base_q  <= r_base_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
        end
    end

    assign S_AXI.AWREADY = (w_state_q == W_IDLE);
    assign S_AXI.WREADY  = (w_state_q == W_DATA);
    assign S_AXI.BVALID  = (w_state_q == W_RESP);
    assign S_AXI.BID     = w_id_q;
    assign S_AXI.BRESP   = b_resp_q;
    assign S_AXI.ARREADY = (r_state_q == R_IDLE);
    assign S_AXI.RVALID  = (r_state_q == R_DATA);
    assign S_AXI.RID     = r_id_q;
    assign S_AXI.RDATA   = r_err ? '0 : mem_rdata;
    assign S_AXI.RRESP   = ((r_state_q == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI.RLAST   = r_last;

    assign busy = {r_state_q != R_IDLE, w_state_q != W_IDLE};

endmodule

// File: tb/tb_rip_axi_ram_responder.sv
// tb/tb_rip_axi_ram_responder.sv - randomized self-checking bench with a word-array reference model
module tb_rip_axi_ram_responder;
    import rip_axi_const::*;

    localparam int AW = 32, IW = 4, DW = 32, WORDS = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_base = 32'h1000_0000;
    logic [1:0]    busy;

    rip_axi_interface #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) axi ();

    rip_axi_ram_responder #(.ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(DW),
                            .MEM_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .mem_base(mem_base), .busy(busy), .S_AXI(axi)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0, throttle = 0;
    logic [31:0] model [WORDS];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rdat [256];
    logic [1:0]  rrsp [256];
    logic        rlst [256];
    logic        rid_bad, stall_bad;

    function automatic int widx(input logic [31:0] a, input logic [31:0] base);
        return int'(((a - base) >> 2) % WORDS);
    endfunction

    function automatic bit oor(input logic [31:0] a, input logic [31:0] base);
`ifdef RIP_AXI_RAM_RANGE_CHECK_EN
        return (a < base) || (((a - base) >> 2) >= WORDS);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
        return (burst == BURST_FIXED) ? a : a + 32'(4 * b);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input int last_at, output logic [1:0] resp);
        int e; logic [31:0] a; bit err;
        e   = (last_at >= 0 && last_at < int'(len)) ? last_at : int'(len);
        err = (burst == BURST_WRAP) || (last_at != int'(len));
        for (int b = 0; b <= e; b++) begin
            a = beat_addr(addr, burst, b);
            if (oor(a, mem_base)) err = 1'b1;
            else if (burst != BURST_WRAP)
                for (int k = 0; k < 4; k++)
                    if (sbuf[b][k]) model[widx(a, mem_base)][8*k +: 8] = wbuf[b][8*k +: 8];
        end
        resp = err ? RESP_SLVERR : RESP_OKAY;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input logic [1:0] burst, input int b);
        logic [31:0] a;
        a = beat_addr(addr, burst, b);
        if (burst == BURST_WRAP || oor(a, mem_base)) return 32'h0;
        return model[widx(a, mem_base)];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] addr, input logic [1:0] burst, input int b);
        return (burst == BURST_WRAP || oor(beat_addr(addr, burst, b), mem_base)) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int last_at, input logic [IW-1:0] id,
                            output logic [1:0] resp, output logic [IW-1:0] bid);
        int e, t;
        e = (last_at >= 0 && last_at < int'(len)) ? last_at : int'(len);
        @(negedge clk);
        axi.AWVALID = 1'b1; axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWID = id;
        t = 0;
        while (!axi.AWREADY && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL aw_timeout got=0 exp=1"); end
        @(negedge clk);
        axi.AWVALID = 1'b0;
        for (int b = 0; b <= e; b++) begin
            if (throttle != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            axi.WVALID = 1'b1; axi.WDATA = wbuf[b]; axi.WSTRB = sbuf[b]; axi.WLAST = (b == last_at);
            t = 0;
            while (!axi.WREADY && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) begin checks++; errors++; $display("FAIL w_timeout beat=%0d", b); end
            @(negedge clk);
            axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        end
        if (throttle != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        t = 0;
        while (!axi.BVALID && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL b_timeout got=0 exp=1"); end
        resp = axi.BRESP; bid = axi.BID;
        axi.BREADY = 1'b1;
        @(negedge clk);
        axi.BREADY = 1'b0;
    endtask

    // mode 0: RREADY high; 1: toggles 1,0,1,0 from the first RVALID cycle; 2: random
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [IW-1:0] id, input int mode);
        int t, nb; logic stalled, pl; logic [31:0] pd; logic [1:0] pr;
        rid_bad = 1'b0; stall_bad = 1'b0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0;
        @(negedge clk);
        axi.ARVALID = 1'b1; axi.ARADDR = addr; axi.ARLEN = len; axi.ARBURST = burst; axi.ARID = id;
        t = 0;
        while (!axi.ARREADY && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL ar_timeout got=0 exp=1"); end
        @(negedge clk);
        axi.ARVALID = 1'b0;
        nb = 0; t = 0;
        while (nb <= int'(len) && t < 2000) begin
            case (mode)
                0:       axi.RREADY = 1'b1;
                1:       axi.RREADY = (t % 2 == 0);
                default: axi.RREADY = 1'($urandom_range(0, 1));
            endcase
            if (axi.RVALID) begin
                if (stalled && (axi.RDATA !== pd || axi.RRESP !== pr || axi.RLAST !== pl)) stall_bad = 1'b1;
                if (axi.RID !== id) rid_bad = 1'b1;
                if (axi.RREADY) begin
                    rdat[nb] = axi.RDATA; rrsp[nb] = axi.RRESP; rlst[nb] = axi.RLAST;
                    nb++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; pd = axi.RDATA; pr = axi.RRESP; pl = axi.RLAST;
                end
            end
            @(negedge clk);
            t++;
        end
        axi.RREADY = 1'b0;
        if (nb <= int'(len)) begin checks++; errors++; $display("FAIL r_timeout got=%0d exp=%0d", nb, int'(len) + 1); end
    endtask

    task automatic check_read(input string name, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst);
        for (int b = 0; b <= int'(len); b++) begin
            checks++;
            if (rdat[b] !== exp_rdata(addr, burst, b) || rrsp[b] !== exp_rresp(addr, burst, b) ||
                rlst[b] !== (b == int'(len))) begin
                errors++;
                $display("FAIL %s beat=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", name, b, rdat[b], rrsp[b],
                         rlst[b], exp_rdata(addr, burst, b), exp_rresp(addr, burst, b), b == int'(len));
            end
        end
        checks++;
        if (rid_bad !== 1'b0 || stall_bad !== 1'b0) begin
            errors++; $display("FAIL %s_rid_stall got=%0d%0d exp=00", name, rid_bad, stall_bad);
        end
    endtask

    task automatic test_reset();
        axi.AWVALID = 0; axi.AWID = 0; axi.AWADDR = 0; axi.AWLEN = 0; axi.AWBURST = 0;
        axi.WVALID = 0; axi.WDATA = 0; axi.WSTRB = 0; axi.WLAST = 0; axi.BREADY = 0;
        axi.ARVALID = 0; axi.ARID = 0; axi.ARADDR = 0; axi.ARLEN = 0; axi.ARBURST = 0; axi.RREADY = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST} !== 6'b110000) begin
            errors++; $display("FAIL reset_handshake got=%b exp=110000",
                {axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST});
        end
        checks++;
        if (axi.BRESP !== RESP_OKAY || axi.RRESP !== RESP_OKAY || busy !== 2'b00) begin
            errors++; $display("FAIL reset_resp_busy got=%0d/%0d/%b exp=0/0/00", axi.BRESP, axi.RRESP, busy);
        end
    endtask

    task automatic fill_memory();
        logic [1:0] resp, er; logic [IW-1:0] bid;
        for (int blk = 0; blk < WORDS / 256; blk++) begin
            for (int b = 0; b < 256; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
            model_write(mem_base + 32'(blk * 1024), 8'd255, BURST_INCR, 255, er);
            do_write(mem_base + 32'(blk * 1024), 8'd255, BURST_INCR, 255, 4'(blk), resp, bid);
            checks++;
            if (resp !== er) begin errors++; $display("FAIL fill_resp got=%0d exp=%0d", resp, er); end
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; logic [IW-1:0] bid;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        model[widx(mem_base + 32'h10, mem_base)] = 32'hDEADBEEF;
        do_write(mem_base + 32'h10, 8'd0, BURST_INCR, 0, 4'd3, resp, bid);
        checks++;
        if (resp !== RESP_OKAY || bid !== 4'd3) begin
            errors++; $display("FAIL single_b got=%0d/%0d exp=0/3", resp, bid);
        end
        do_read(mem_base + 32'h10, 8'd0, BURST_INCR, 4'd5, 0);
        checks++;
        if (rdat[0] !== 32'hDEADBEEF || rlst[0] !== 1'b1 || rrsp[0] !== RESP_OKAY) begin
            errors++; $display("FAIL single_r got=%h/%0d exp=deadbeef/1", rdat[0], rlst[0]);
        end
    endtask

    task automatic test_incr_stall();
        logic [1:0] resp, er; logic [IW-1:0] bid;
        for (int b = 0; b < 4; b++) begin wbuf[b] = 32'(b + 1); sbuf[b] = 4'hF; end
        model_write(mem_base, 8'd3, BURST_INCR, 3, er);
        do_write(mem_base, 8'd3, BURST_INCR, 3, 4'd1, resp, bid);
        checks++;
        if (resp !== RESP_OKAY) begin errors++; $display("FAIL incr_b got=%0d exp=0", resp); end
        do_read(mem_base, 8'd3, BURST_INCR, 4'd9, 1);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rdat[b] !== 32'(b + 1) || rlst[b] !== (b == 3)) begin
                errors++; $display("FAIL incr_r beat=%0d got=%h/%0d exp=%h/%0d", b, rdat[b], rlst[b], b + 1, b == 3);
            end
        end
        checks++;
        if (stall_bad !== 1'b0 || rid_bad !== 1'b0) begin
            errors++; $display("FAIL incr_stall got=%0d%0d exp=00", stall_bad, rid_bad);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [IW-1:0] bid;
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(mem_base + 32'h40, 8'd0, BURST_INCR, 0, 4'd2, resp, bid);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(mem_base + 32'h40, 8'd0, BURST_INCR, 0, 4'd2, resp, bid);
        model[widx(mem_base + 32'h40, mem_base)] = 32'h11BB33DD;
        do_read(mem_base + 32'h40, 8'd0, BURST_INCR, 4'd2, 0);
        checks++;
        if (rdat[0] !== 32'h11BB33DD) begin errors++; $display("FAIL strobe got=%h exp=11bb33dd", rdat[0]); end
    endtask

    task automatic test_index_wrap();
        logic [1:0] resp, er; logic [IW-1:0] bid;
        wbuf[0] = 32'h5A5A0001; sbuf[0] = 4'hF;
        model_write(mem_base + 32'(4 * WORDS), 8'd0, BURST_INCR, 0, er);
        do_write(mem_base + 32'(4 * WORDS), 8'd0, BURST_INCR, 0, 4'd6, resp, bid);
        checks++;
        if (resp !== er) begin errors++; $display("FAIL wrapidx_b got=%0d exp=%0d", resp, er); end
        do_read(mem_base, 8'd0, BURST_INCR, 4'd6, 0);
        check_read("wrapidx_r", mem_base, 8'd0, BURST_INCR);
    endtask

    task automatic test_simultaneous();
        logic [1:0] resp; logic [IW-1:0] bid; int t;
        wbuf[0] = 32'h9; sbuf[0] = 4'hF;
        do_write(mem_base + 32'd28, 8'd0, BURST_INCR, 0, 4'd1, resp, bid);
        @(negedge clk);
        axi.AWVALID = 1; axi.AWADDR = mem_base + 32'd28; axi.AWLEN = 0; axi.AWBURST = BURST_INCR; axi.AWID = 4'd1;
        axi.ARVALID = 1; axi.ARADDR = mem_base + 32'd28; axi.ARLEN = 1; axi.ARBURST = BURST_FIXED; axi.ARID = 4'd2;
        @(negedge clk);
        axi.AWVALID = 0; axi.ARVALID = 0;
        axi.WVALID = 1; axi.WDATA = 32'h5; axi.WSTRB = 4'hF; axi.WLAST = 1; axi.RREADY = 1;
        checks++;
        if (axi.RVALID !== 1'b1 || axi.WREADY !== 1'b1 || axi.RDATA !== 32'h9) begin
            errors++; $display("FAIL simul_pre got=%0d%0d/%h exp=11/00000009", axi.RVALID, axi.WREADY, axi.RDATA);
        end
        @(negedge clk);
        axi.WVALID = 0; axi.WLAST = 0;
        checks++;
        if (axi.RVALID !== 1'b1 || axi.RLAST !== 1'b1 || axi.RDATA !== 32'h5) begin
            errors++; $display("FAIL simul_post got=%0d%0d/%h exp=11/00000005", axi.RVALID, axi.RLAST, axi.RDATA);
        end
        @(negedge clk);
        axi.RREADY = 0;
        t = 0;
        while (!axi.BVALID && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== RESP_OKAY || axi.BID !== 4'd1) begin
            errors++; $display("FAIL simul_b got=%0d/%0d/%0d exp=1/0/1", axi.BVALID, axi.BRESP, axi.BID);
        end
        axi.BREADY = 1;
        @(negedge clk);
        axi.BREADY = 0;
        model[7] = 32'h5;
    endtask

    task automatic test_bad_wlast();
        logic [1:0] resp, er; logic [IW-1:0] bid;
        for (int b = 0; b < 4; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        model_write(mem_base + 32'h80, 8'd3, BURST_INCR, 1, er);
        do_write(mem_base + 32'h80, 8'd3, BURST_INCR, 1, 4'd4, resp, bid);
        checks++;
        if (resp !== er || resp !== RESP_SLVERR) begin errors++; $display("FAIL early_wlast got=%0d exp=%0d", resp, er); end
        do_read(mem_base + 32'h80, 8'd3, BURST_INCR, 4'd4, 0);
        check_read("early_wlast_r", mem_base + 32'h80, 8'd3, BURST_INCR);
        model_write(mem_base + 32'hA0, 8'd1, BURST_INCR, -1, er);
        do_write(mem_base + 32'hA0, 8'd1, BURST_INCR, -1, 4'd4, resp, bid);
        checks++;
        if (resp !== er || resp !== RESP_SLVERR || busy !== 2'b00) begin
            errors++; $display("FAIL missing_wlast got=%0d/%b exp=%0d/00", resp, busy, er);
        end
    endtask

    task automatic test_wrap_burst();
        logic [1:0] resp, er; logic [IW-1:0] bid;
        for (int b = 0; b < 4; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        model_write(mem_base + 32'h100, 8'd3, BURST_WRAP, 3, er);
        do_write(mem_base + 32'h100, 8'd3, BURST_WRAP, 3, 4'd7, resp, bid);
        checks++;
        if (resp !== RESP_SLVERR || er !== RESP_SLVERR) begin errors++; $display("FAIL wrap_b got=%0d exp=2", resp); end
        do_read(mem_base + 32'h100, 8'd3, BURST_INCR, 4'd7, 0);
        check_read("wrap_unchanged", mem_base + 32'h100, 8'd3, BURST_INCR);
        do_read(mem_base + 32'h100, 8'd1, BURST_WRAP, 4'd8, 2);
        check_read("wrap_r", mem_base + 32'h100, 8'd1, BURST_WRAP);
    endtask

    task automatic test_reset_mid_burst();
        int t; logic seen_b;
        for (int b = 0; b < 2; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        for (int b = 0; b < 2; b++) model[widx(mem_base + 32'(32'h200 + 4 * b), mem_base)] = wbuf[b];
        @(negedge clk);
        axi.AWVALID = 1; axi.AWADDR = mem_base + 32'h200; axi.AWLEN = 8'd7; axi.AWBURST = BURST_INCR; axi.AWID = 4'd3;
        @(negedge clk);
        axi.AWVALID = 0;
        for (int b = 0; b < 2; b++) begin
            axi.WVALID = 1; axi.WDATA = wbuf[b]; axi.WSTRB = 4'hF;
            @(negedge clk);
        end
        axi.WVALID = 0;
        checks++;
        if (busy !== 2'b01) begin errors++; $display("FAIL midburst_busy got=%b exp=01", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.AWREADY !== 1'b1 || busy !== 2'b00 || axi.BVALID !== 1'b0 || axi.WREADY !== 1'b0) begin
            errors++; $display("FAIL post_reset got=%0d/%b/%0d/%0d exp=1/00/0/0", axi.AWREADY, busy, axi.BVALID, axi.WREADY);
        end
        seen_b = 1'b0;
        for (t = 0; t < 5; t++) begin if (axi.BVALID) seen_b = 1'b1; @(negedge clk); end
        checks++;
        if (seen_b !== 1'b0) begin errors++; $display("FAIL post_reset_bvalid got=1 exp=0"); end
        do_read(mem_base + 32'h200, 8'd1, BURST_INCR, 4'd3, 0);
        check_read("post_reset_keep", mem_base + 32'h200, 8'd1, BURST_INCR);
    endtask

    task automatic test_random();
        logic [1:0] resp, er, burst; logic [IW-1:0] bid, id; logic [7:0] len; logic [31:0] addr;
        throttle = 1;
        for (int it = 0; it < 30; it++) begin
            mem_base = {8'($urandom_range(0, 255)), 24'h0};
            len   = 8'($urandom_range(0, 15));
            burst = ($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_INCR;
            addr  = mem_base + 32'(4 * $urandom_range(0, WORDS - 17)) + 32'($urandom_range(0, 3));
            id    = 4'($urandom);
            for (int b = 0; b <= int'(len); b++) begin wbuf[b] = $urandom; sbuf[b] = 4'($urandom); end
            model_write(addr, len, burst, int'(len), er);
            do_write(addr, len, burst, int'(len), id, resp, bid);
            checks++;
            if (resp !== er || bid !== id) begin
                errors++; $display("FAIL rand_b it=%0d got=%0d/%0d exp=%0d/%0d", it, resp, bid, er, id);
            end
            len   = 8'($urandom_range(0, 15));
            burst = ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR;
            addr  = (it % 2 == 0) ? addr : mem_base + 32'(4 * $urandom_range(0, WORDS - 17));
            do_read(addr, len, burst, 4'($urandom), 2);
            check_read("rand_r", addr, len, burst);
        end
        throttle = 0;
        mem_base = 32'h1000_0000;
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_single();
        test_incr_stall();
        test_strobe();
        test_index_wrap();
        test_simultaneous();
        test_bad_wlast();
        test_wrap_burst();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
